// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode-and-issue stage feeding the alu through a 2-entry skid buffer
//
// Decodes LUI/AUIPC/ADD/ADDI into an (ALUOp, A, B, out_rd) entry and holds up
// to two entries (head + skid) so the ALU side can stall without losing work.
// Illegal encodings are consumed, pulse `illegal` and bump a saturating count.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake (in_ready registered)
//   in_instr, in_pc           instruction word and its PC
//   in_rs1, in_rs2            register operands already read upstream
//   out_valid/out_ready       ALU-side handshake
//   A, B, ALUOp, out_rd       head entry presented to the ALU
//   illegal, illegal_cnt      one-cycle illegal pulse, saturating illegal count
`timescale 1ns/1ps

module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  ALUOp,
    output logic [4:0]  out_rd,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LUI   = 5'b00001;
    localparam logic [4:0] OP_AUIPC = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state, next_state;

    logic        dec_legal;
    logic [4:0]  dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [31:0] imm_u;
    logic [31:0] imm_i;

    logic        accept;
    logic        legal_acc;
    logic        illegal_acc;
    logic        issue;
    logic        load_head_new;
    logic        load_head_skid;
    logic        load_skid;

    logic [31:0] skid_a;
    logic [31:0] skid_b;
    logic [4:0]  skid_op;
    logic [4:0]  skid_rd;

    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_NOP;
        dec_a     = 32'h0;
        dec_b     = 32'h0;
        case (in_instr[6:0])
            7'b0110111: begin
                dec_legal = 1'b1;
                dec_op    = OP_LUI;
                dec_b     = imm_u;
            end
            7'b0010111: begin
                dec_legal = 1'b1;
                dec_op    = OP_AUIPC;
                dec_a     = in_pc;
                dec_b     = imm_u;
            end
            7'b0110011: begin
                if (in_instr[14:12] == 3'b000 && in_instr[31:25] == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_ADD;
                    dec_a     = in_rs1;
                    dec_b     = in_rs2;
                end
            end
            7'b0010011: begin
                if (in_instr[14:12] == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_ADD;
                    dec_a     = in_rs1;
                    dec_b     = imm_i;
                end
            end
            default: ;
        endcase
    end

    assign out_valid   = (state != ST_EMPTY);
    assign accept      = in_valid && in_ready;
    assign legal_acc   = accept && dec_legal;
    assign illegal_acc = accept && !dec_legal;
    assign issue       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Occupancy only reacts to legal accepts and issues; illegal accepts
    // are invisible here. in_ready is 0 in TWO, so no accept arrives there.
    always_comb begin
        next_state     = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (legal_acc) begin
                    next_state    = ST_ONE;
                    load_head_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (legal_acc && issue) begin
                    load_head_new = 1'b1;
                end else if (legal_acc) begin
                    next_state = ST_TWO;
                    load_skid  = 1'b1;
                end else if (issue) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (issue) begin
                    next_state     = ST_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    // Head and skid registers. The head is left untouched when it empties so
    // the outputs keep showing the last issued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A       <= 32'h0;
            B       <= 32'h0;
            ALUOp   <= OP_NOP;
            out_rd  <= 5'd0;
            skid_a  <= 32'h0;
            skid_b  <= 32'h0;
            skid_op <= OP_NOP;
            skid_rd <= 5'd0;
        end else begin
            if (load_head_new) begin
                A      <= dec_a;
                B      <= dec_b;
                ALUOp  <= dec_op;
                out_rd <= in_instr[11:7];
            end else if (load_head_skid) begin
                A      <= skid_a;
                B      <= skid_b;
                ALUOp  <= skid_op;
                out_rd <= skid_rd;
            end
            if (load_skid) begin
                skid_a  <= dec_a;
                skid_b  <= dec_b;
                skid_op <= dec_op;
                skid_rd <= in_instr[11:7];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready    <= 1'b1;
            illegal     <= 1'b0;
            illegal_cnt <= 8'd0;
        end else begin
            in_ready <= (next_state != ST_TWO);
            illegal  <= illegal_acc;
            if (illegal_acc && illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

endmodule
